fifo_out_arbiter: RTL and testbench
===================================

Name: fifo_out_arbiter

Overview:
- Router output stage sitting directly downstream of the per-input `fifo` instances. It consumes their head flits.
- Each cycle it picks one non-empty input FIFO by round-robin, pops it and captures the flit into a one-entry output register.
- It then presents the flit to the next hop's input FIFO using that FIFO's `write`/`full` handshake.
- It gives fair, flit-level sharing of one output link among NUM_IN inputs, at full throughput when the downstream FIFO is not full.

Parameters:
- NUM_IN, 4: number of upstream input FIFOs (2..8).
- FLIT_W, 16: flit width. Equals HDR_SZ+PL_SZ+ADDR_SZ at integration.
- CNT_W, 16: width of the forwarded-flit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 means reset.
- in_empty  input  NUM_IN  `empty` flags of the upstream FIFOs; bit i belongs to input i.
- in_items  input  NUM_IN*FLIT_W  `item_out` of the upstream FIFOs; input i occupies bits [i*FLIT_W +: FLIT_W].
- in_read  output  NUM_IN  pop strobes to the upstream FIFOs, one-hot or zero. Combinational.
- dn_full  input  1  `full` flag of the downstream FIFO.
- dn_write  output  1  write strobe to the downstream FIFO. Registered.
- dn_item  output  FLIT_W  flit to the downstream FIFO. Registered.
- grant_id  output  log2(NUM_IN)  index of the input whose flit is currently held in dn_item. Registered.
- fwd_count  output  CNT_W  number of flits accepted downstream. Saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - out_valid=0, so dn_write=0.
  - dn_item=0, grant_id=0, fwd_count=0.
  - Round-robin pointer last_grant=NUM_IN-1, so input 0 has first priority.
  - in_read is forced to 0 while reset is low.
- Reset mid-operation: a held flit is discarded and is not counted. Upstream FIFOs are not popped during the reset cycle.
- Downstream transfer:
  - xfer = out_valid & !dn_full.
  - dn_write = out_valid. The downstream FIFO ignores the write while full, so dn_write is held asserted until xfer occurs.
  - dn_item is stable while out_valid=1 and xfer=0.
- Load enable: can_load = !out_valid | xfer. This gives back-to-back forwarding with no bubble.
- Request vector: req[i] = !in_empty[i].
- Arbitration:
  - Combinational, evaluated when can_load=1 and req!=0.
  - Inputs are searched in order last_grant+1, last_grant+2, ... modulo NUM_IN. The first requester found becomes g.
  - in_read[g]=1 in the same cycle; every other bit of in_read is 0.
  - If can_load=0 or req==0, in_read=0.
- Capture: on the edge where in_read[g]=1:
  - dn_item <= in_items[g] (the upstream FIFO outputs its head combinationally before the pop).
  - grant_id <= g, out_valid <= 1, last_grant <= g.
- Idle: if xfer=1 and no grant is made, out_valid <= 0. last_grant is unchanged whenever there is no grant.
- Latency: 1 cycle from the pop to dn_write being asserted.
- Throughput: 1 flit per cycle when dn_full=0 and at least one input is non-empty.
- Fairness: with all inputs continuously non-empty, grants rotate 0,1,2,...,NUM_IN-1,0,... Any single requester waits at most NUM_IN-1 grants.
- Pointer wrap: last_grant=NUM_IN-1 wraps the search start to 0.
- fwd_count:
  - Increments by 1 on each xfer.
  - Holds at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - An xfer and a new capture in the same cycle is the normal streaming case; out_valid stays 1.
  - An input that becomes empty in the cycle after its grant is simply skipped from then on.
- Upstream FIFOs are never popped while empty, so in_read[i] implies !in_empty[i].
- dn_full=1 with out_valid=1:
  - No pops occur.
  - The held flit is retained indefinitely.

Test Plan:
1. Reset, then only input 2 non-empty with head 0x00A5, dn_full=0 → in_read=4'b0100 in cycle 0; cycle 1: dn_write=1, dn_item=0x00A5, grant_id=2; fwd_count=1 after cycle 1.
2. All 4 inputs always non-empty, heads 0x1000+i, dn_full=0, 8 cycles → grants 0,1,2,3,0,1,2,3; dn_write high every cycle from cycle 1; fwd_count=8 after 9 cycles.
3. Flit 0x0033 held in dn_item, then dn_full=1 for 5 cycles with all inputs non-empty → in_read=0 throughout, dn_item stays 0x0033, dn_write stays 1, fwd_count unchanged. After dn_full drops: transfer, and the next grant goes to last_grant+1 in the same cycle.
4. last_grant=3, inputs 1 and 3 non-empty → input 1 is granted (wrap past 0); the next grant is input 3.
5. Streaming active with out_valid=1, reset driven low for 1 cycle → dn_write=0, fwd_count=0, in_read=0 during reset, no upstream pop. After release, input 0 has first priority.
6. CNT_W=4, 20 flits forwarded → fwd_count saturates at 15 and stays there.

Source files
------------

// File: rtl/fifo_out_arbiter.sv
// Router output stage: round-robin pops one non-empty upstream FIFO per cycle into a
// one-entry output register and forwards it over the downstream write/full handshake.
module fifo_out_arbiter #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 16,
  parameter int CNT_W  = 16,
  localparam int GID_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_empty,
  input  logic [NUM_IN*FLIT_W-1:0] in_items,
  output logic [NUM_IN-1:0]        in_read,
  input  logic                     dn_full,
  output logic                     dn_write,
  output logic [FLIT_W-1:0]        dn_item,
  output logic [GID_W-1:0]         grant_id,
  output logic [CNT_W-1:0]         fwd_count
);

  logic              out_valid;
  logic [GID_W-1:0]  last_grant;
  logic [NUM_IN-1:0] req;
  logic              xfer;
  logic              can_load;
  logic              found;
  logic              grant;
  logic [GID_W-1:0]  g;
  logic [FLIT_W-1:0] sel_item;
  int                idx;

  assign req      = ~in_empty;
  assign xfer     = out_valid & ~dn_full;
  assign can_load = ~out_valid | xfer;
  assign dn_write = out_valid;

  // Search starts one past the last winner so every requester is reached within NUM_IN grants.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(last_grant) + k) % NUM_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = GID_W'(idx);
      end
    end
  end

  assign grant = reset & can_load & found;

  always_comb begin
    in_read = '0;
    if (grant) in_read[g] = 1'b1;
  end

  assign sel_item = in_items[int'(g)*FLIT_W +: FLIT_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      dn_item    <= '0;
      grant_id   <= '0;
      last_grant <= GID_W'(NUM_IN - 1);
      fwd_count  <= '0;
    end else begin
      if (grant) begin
        dn_item    <= sel_item;
        grant_id   <= g;
        out_valid  <= 1'b1;
        last_grant <= g;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer && (fwd_count != {CNT_W{1'b1}}))
        fwd_count <= fwd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// Self-checking bench: a reference model predicts pops and pushes expected flits to a
// scoreboard that is drained whenever the DUT completes a downstream transfer.
module tb_fifo_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_empty;
  logic [63:0] in_items;
  logic [3:0]  in_read, in_read4;
  logic        dn_full;
  logic        dn_write, dn_write4;
  logic [15:0] dn_item, dn_item4;
  logic [1:0]  grant_id, grant_id4;
  logic [15:0] fwd_count;
  logic [3:0]  fwd_count4;
  logic [15:0] items [4];

  typedef struct {
    int          gid;
    logic [15:0] item;
  } exp_t;
  exp_t sb[$];

  logic        m_valid;
  int          m_last;
  int          m_count;
  int          m_count4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) in_items[i*16 +: 16] = items[i];
  end

  fifo_out_arbiter #(.NUM_IN(4), .FLIT_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_items(in_items),
    .in_read(in_read), .dn_full(dn_full), .dn_write(dn_write),
    .dn_item(dn_item), .grant_id(grant_id), .fwd_count(fwd_count)
  );

  fifo_out_arbiter #(.NUM_IN(4), .FLIT_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_items(in_items),
    .in_read(in_read4), .dn_full(dn_full), .dn_write(dn_write4),
    .dn_item(dn_item4), .grant_id(grant_id4), .fwd_count(fwd_count4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge, then settle before direct checks.
  task automatic applyStimulus(input logic [3:0] empty, input logic full);
    in_empty = empty;
    dn_full  = full;
    #1;
  endtask

  task automatic modelReset();
    sb.delete();
    m_valid  = 1'b0;
    m_last   = 3;
    m_count  = 0;
    m_count4 = 0;
  endtask

  // One clock: compare at the falling edge against the model, then advance the model.
  task automatic cycle();
    logic [3:0] exp_read;
    logic       xfer, can_load, found;
    int         g;
    exp_t       e;
    @(negedge clk);
    checkOutput("dn_write", dn_write, m_valid);
    checkOutput("fwd_count", fwd_count, m_count);
    checkOutput("fwd_count4", fwd_count4, m_count4);
    exp_read = '0;
    found    = 1'b0;
    g        = 0;
    xfer     = m_valid && !dn_full;
    can_load = !m_valid || xfer;
    if (reset && can_load) begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && !in_empty[(m_last + k) % 4]) begin
          found = 1'b1;
          g     = (m_last + k) % 4;
        end
      end
      if (found) exp_read[g] = 1'b1;
    end
    checkOutput("in_read", in_read, exp_read);
    if (!reset) begin
      modelReset();
    end else begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
          checkOutput(xfer ? "dn_item" : "dn_hold", dn_item, sb[0].item);
          checkOutput("grant_id", grant_id, sb[0].gid);
          if (xfer) e = sb.pop_front();
        end
      end
      if (found) begin
        e.gid  = g;
        e.item = items[g];
        sb.push_back(e);
        m_valid = 1'b1;
        m_last  = g;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      if (xfer) begin
        if (m_count < 65535) m_count++;
        if (m_count4 < 15) m_count4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic setHeads();
    for (int i = 0; i < 4; i++) items[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    reset    = 1'b0;
    in_empty = 4'hF;
    dn_full  = 1'b0;
    setHeads();
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_dn_write", dn_write, 1'b0);
    checkOutput("rst_dn_item", dn_item, 16'h0000);
    checkOutput("rst_grant_id", grant_id, 2'd0);
    checkOutput("rst_fwd_count", fwd_count, 16'd0);
    checkOutput("rst_in_read", in_read, 4'b0000);
    reset = 1'b1;

    $display("[TB] single requester on input 2");
    items[2] = 16'h00A5;
    applyStimulus(4'b1011, 1'b0);
    checkOutput("t1_in_read", in_read, 4'b0100);
    cycle();
    applyStimulus(4'b1111, 1'b0);
    checkOutput("t1_dn_write", dn_write, 1'b1);
    checkOutput("t1_dn_item", dn_item, 16'h00A5);
    checkOutput("t1_grant_id", grant_id, 2'd2);
    cycle();
    checkOutput("t1_fwd_count", fwd_count, 16'd1);

    $display("[TB] all inputs streaming");
    setHeads();
    doReset();
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 8; c++) begin
      checkOutput("t2_rotate", in_read, 4'b0001 << (c % 4));
      cycle();
    end
    applyStimulus(4'b1111, 1'b0);
    cycle();
    checkOutput("t2_fwd_count", fwd_count, 16'd8);

    $display("[TB] downstream backpressure");
    repeat (2) cycle();
    items[1] = 16'h0033;
    applyStimulus(4'b1101, 1'b1);
    cycle();
    items[1] = 16'h1001;
    applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t3_no_pop", in_read, 4'b0000);
      checkOutput("t3_hold", dn_item, 16'h0033);
      cycle();
    end
    checkOutput("t3_count_held", fwd_count, 16'd8);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t3_next_grant", in_read, 4'b0100);
    cycle();

    $display("[TB] pointer wrap");
    applyStimulus(4'b1111, 1'b0);
    repeat (2) cycle();
    applyStimulus(4'b0111, 1'b0);
    cycle();
    applyStimulus(4'b0101, 1'b0);
    checkOutput("t4_wrap", in_read, 4'b0010);
    cycle();
    checkOutput("t4_next", in_read, 4'b1000);
    cycle();

    $display("[TB] reset while streaming");
    applyStimulus(4'b0000, 1'b0);
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    checkOutput("t5_in_read_rst", in_read, 4'b0000);
    cycle();
    checkOutput("t5_dn_write", dn_write, 1'b0);
    checkOutput("t5_fwd_count", fwd_count, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("t5_first_prio", in_read, 4'b0001);

    $display("[TB] counter saturation");
    for (int c = 0; c < 21; c++) cycle();
    applyStimulus(4'b1111, 1'b0);
    repeat (2) cycle();
    checkOutput("t6_sat4", fwd_count4, 4'd15);
    checkOutput("t6_count16", fwd_count, 16'd21);
    applyStimulus(4'b0000, 1'b0);
    repeat (4) cycle();
    checkOutput("t6_sat4_hold", fwd_count4, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
